// File: rtl/alu_8bit_checker.sv
// alu_8bit_checker: recomputes ALU results, compares against observed Y/Cout and keeps run statistics
module alu_8bit_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [2:0]       in_sel,
  input  logic [7:0]       in_y,
  input  logic             in_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       fail_sel,
  output logic [7:0]       fail_a,
  output logic [7:0]       fail_b,
  output logic [7:0]       fail_y_exp,
  output logic             fail_cout_exp
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [8:0] exp_res;
  logic accept, fail, last;
  assign in_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  assign accept = in_valid && in_ready;
  assign fail = exp_res != {in_cout, in_y};
  assign last = vec_count == CNT_W'(NUM_VECTORS - 1);
  // reference ALU: expected {Cout,Y}; subtraction carry is the carry of A+~B+1
  always_comb begin
    exp_res = '0;
    case (in_sel)
      3'd0: exp_res = {1'b0, in_a} + {1'b0, in_b};
      3'd1: exp_res = {1'b0, in_a} + {1'b0, ~in_b} + 9'd1;
      3'd2: exp_res = {1'b0, in_a & in_b};
      3'd3: exp_res = {1'b0, in_a | in_b};
      3'd4: exp_res = {1'b0, in_a ^ in_b};
      3'd5: exp_res = {1'b0, ~in_a};
      3'd6: exp_res = {in_a[7], in_a[6:0], 1'b0};
      default: exp_res = {in_a[0], 1'b0, in_a[7:1]};
    endcase
  end
  // run state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // start wins over everything; the accept that reaches NUM_VECTORS ends the run
  always_comb begin
    state_nx = state;
    if (start) state_nx = RUN;
    else if (accept && last) state_nx = DONE;
  end
  // statistics, mismatch pulse and first-failure capture
  always_ff @(posedge clk or posedge rst)
    if (rst || start) begin
      mismatch <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
      fail_sel <= '0;
      fail_a <= '0;
      fail_b <= '0;
      fail_y_exp <= '0;
      fail_cout_exp <= 1'b0;
    end else begin
      mismatch <= accept && fail;
      if (accept && vec_count != '1) vec_count <= vec_count + 1'b1;
      if (accept && fail && err_count != '1) err_count <= err_count + 1'b1;
      if (accept && fail && err_count == '0) begin
        fail_sel <= in_sel;
        fail_a <= in_a;
        fail_b <= in_b;
        fail_y_exp <= exp_res[7:0];
        fail_cout_exp <= exp_res[8];
      end
    end
endmodule

// File: tb/tb_alu_8bit_checker.sv
// tb_alu_8bit_checker: table-driven vectors with a mismatch scoreboard for alu_8bit_checker
module tb_alu_8bit_checker;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_cout = 0;
  logic [7:0] in_a = 0, in_b = 0, in_y = 0;
  logic [2:0] in_sel = 0;
  logic in_ready, busy, done, pass, mismatch, fail_cout_exp;
  logic [7:0] vec_count, err_count, fail_a, fail_b, fail_y_exp;
  logic [2:0] fail_sel;
  int errors = 0, checks = 0;
  typedef struct packed {logic [7:0] a, b; logic [2:0] sel; logic [7:0] y; logic c; logic f;} vec_t;
  vec_t good [8];
  vec_t bad [8];
  vec_t sub [3];
  bit sb [$];

  alu_8bit_checker #(.NUM_VECTORS(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_y(in_y), .in_cout(in_cout),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .vec_count(vec_count), .err_count(err_count), .fail_sel(fail_sel), .fail_a(fail_a),
    .fail_b(fail_b), .fail_y_exp(fail_y_exp), .fail_cout_exp(fail_cout_exp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] outs();
    return {in_ready, busy, done, pass, mismatch, vec_count, err_count,
            fail_sel, fail_a, fail_b, fail_y_exp, fail_cout_exp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    in_a = v.a; in_b = v.b; in_sel = v.sel; in_y = v.y; in_cout = v.c;
    in_valid = 1;
    chk("in_ready_before_send", in_ready, 1);
    sb.push_back(v.f);
    tick();
    in_valid = 0;
    chk("mismatch_pulse", mismatch, sb.pop_front());
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    chk("start_enters_run", {busy, in_ready, done, vec_count, err_count}, {3'b110, 16'h0});
  endtask

  initial begin
    logic [7:0] gy [8] = '{8'h76, 8'hDE, 8'h88, 8'hEE, 8'h66, 8'h55, 8'h54, 8'h55};
    logic gc [8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      good[i] = '{8'hAA, 8'hCC, 3'(i), gy[i], gc[i], 1'b0};
      bad[i] = good[i];
    end
    bad[0].y = 8'h77; bad[0].f = 1;
    bad[6].c = 0; bad[6].f = 1;
    sub[0] = '{8'h05, 8'h05, 3'd1, 8'h00, 1'b1, 1'b0};
    sub[1] = '{8'h00, 8'h01, 3'd1, 8'hFF, 1'b0, 1'b0};
    sub[2] = '{8'h00, 8'h01, 3'd1, 8'hFF, 1'b1, 1'b1};

    #2;
    chk("reset_outputs", outs(), 49'h0);
    tick(); tick();
    rst = 0;
    tick();
    chk("idle_after_reset", outs(), 49'h0);
    in_valid = 1; in_a = 8'h12; in_sel = 3'd0; in_y = 8'h00;
    tick();
    in_valid = 0;
    chk("idle_valid_ignored", outs(), 49'h0);

    do_start();
    foreach (good[i]) send(good[i]);
    chk("clean_done_pass", {done, pass, busy, in_ready}, 4'b1100);
    chk("clean_counts", {vec_count, err_count}, {8'd8, 8'd0});
    in_valid = 1; in_y = 8'h00;
    tick();
    chk("done_valid_ignored", {in_ready, done, vec_count, err_count, mismatch}, {2'b01, 8'd8, 8'd0, 1'b0});
    in_valid = 0;

    do_start();
    foreach (bad[i]) send(bad[i]);
    chk("bad_done_fail", {done, pass}, 2'b10);
    chk("bad_err_count", err_count, 8'd2);
    chk("bad_first_fail", {fail_sel, fail_a, fail_b, fail_y_exp, fail_cout_exp},
        {3'd0, 8'hAA, 8'hCC, 8'h76, 1'b1});
    tick();
    chk("mismatch_clears_in_done", mismatch, 0);

    do_start();
    chk("start_clears_fail", {fail_sel, fail_a, fail_b, fail_y_exp, fail_cout_exp}, 28'h0);
    foreach (sub[i]) send(sub[i]);
    chk("sub_counts", {vec_count, err_count}, {8'd3, 8'd1});
    chk("sub_first_fail", {fail_sel, fail_a, fail_b, fail_y_exp, fail_cout_exp},
        {3'd1, 8'h00, 8'h01, 8'hFF, 1'b0});
    for (int i = 0; i < 5; i++) send(good[i]);
    chk("sub_run_done", {done, pass, vec_count}, {2'b10, 8'd8});

    do_start();
    start = 1; in_valid = 1;
    in_a = bad[0].a; in_b = bad[0].b; in_sel = bad[0].sel; in_y = bad[0].y; in_cout = bad[0].c;
    tick();
    start = 0; in_valid = 0;
    chk("start_beats_accept", {busy, mismatch, vec_count, err_count}, {2'b10, 16'h0});
    for (int i = 0; i < 3; i++) send(bad[i]);
    chk("pre_reset_counts", {vec_count, err_count}, {8'd3, 8'd1});
    @(negedge clk);
    rst = 1;
    #1;
    chk("async_reset_midrun", outs(), 49'h0);
    tick();
    rst = 0;
    do_start();
    foreach (good[i]) send(good[i]);
    chk("after_reset_pass", {done, pass, vec_count, err_count}, {2'b11, 16'h0800});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
